pwm_sequencer: RTL and testbench
================================

Name: pwm_sequencer

Overview:
Controller that drives the load port (d/sel) of the 16-bit PWM counter. It plays a programmed table of duty-cycle steps: it loads TOP, resynchronises CNT to 0, then writes a new CMP at each period boundary after a per-step hold count. It sits between the register/control logic and the PWM datapath and is the only driver of that block's d and sel inputs.

Parameters:
DEPTH, 8, number of table entries (power of two, 2..16)
HOLD_W, 8, width of per-step hold count (PWM periods)
ADDR_W, $clog2(DEPTH), table index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_we  in  1  write table entry / sequence settings (honoured only when not busy)
cfg_addr  in  ADDR_W  entry index for cfg_we
cfg_cmp  in  16  compare value for entry
cfg_hold  in  HOLD_W  hold count for entry (0 treated as 1)
cfg_top  in  16  period TOP, latched on every accepted cfg_we
cfg_len  in  ADDR_W+1  number of active entries, latched on every accepted cfg_we
loop  in  1  restart at entry 0 after the last entry
start  in  1  begin sequence (pulse)
stop  in  1  abort sequence (pulse)
cnt_in  in  16  PWM counter value (observed)
top_in  in  16  PWM TOP value (observed)
d  out  16  data to PWM load port
sel  out  2  PWM load select: 0 none, 1 cmp, 2 top, 3 cnt
busy  out  1  sequence running
done  out  1  one-cycle pulse at normal completion
step_idx  out  ADDR_W  current entry index

Behaviour:
- Reset: state IDLE; d=0, sel=0, busy=0, done=0, step_idx=0; table cmp/hold cleared to 0, top_reg=0, len_reg=0.
- sel is nonzero only in LOAD_* states; sel=0 in all other states; d=0 whenever sel=0.
- FSM:
  - IDLE: start & !stop & len_reg!=0 -> LOAD_TOP. Start with len_reg=0 is ignored.
  - LOAD_TOP (1 cycle): sel=2, d=top_reg -> LOAD_CNT.
  - LOAD_CNT (1 cycle): sel=3, d=0 -> LOAD_CMP.
  - LOAD_CMP (1 cycle): sel=1, d=table[idx].cmp; hold_cnt<=max(hold,1) -> WAIT.
  - WAIT: a period boundary is any cycle with cnt_in>=top_in. On each boundary hold_cnt decrements. When a boundary occurs with hold_cnt==1:
    - if idx<len_reg-1: idx++ -> LOAD_CMP.
    - else if loop: idx=0 -> LOAD_CMP.
    - else: done=1 for one cycle -> IDLE.
- Latency: start sampled at edge t -> sel=2 during cycle t+1, sel=3 at t+2, sel=1 at t+3.
- busy=1 in every state except IDLE.
- stop: in any non-IDLE state -> IDLE on the next edge, sel=0, no done pulse. PWM keeps its last cmp/top.
- Simultaneous start and stop in IDLE: stop wins.
- start while busy: ignored.
- cfg_we while busy: ignored (table, top_reg and len_reg unchanged).
- cfg_len > DEPTH: saturates to DEPTH.
- step_idx = idx; it updates on the edge that enters LOAD_CMP.
- Reset mid-sequence: immediate return to reset values, independent of clk.

Optional Feature:
PWM_SEQ_PINGPONG_EN
- Defined: adds input port pingpong (1 bit). With loop=1 and pingpong=1, the sequence runs 0..len-1..0 and repeats; end entries are not repeated, and a direction register flips at each end. With len_reg=1, idx stays 0.
- Undefined: no port, no direction register; loop always wraps to entry 0.

Decomposition:
- Package pwm_seq_pkg: state enum (IDLE, LOAD_TOP, LOAD_CNT, LOAD_CMP, WAIT); sel encodings as constants (SEL_NONE=0, SEL_CMP=1, SEL_TOP=2, SEL_CNT=3); packed entry struct {cmp[15:0], hold[HOLD_W-1:0]}.
- One sub-module, pwm_seq_table: DEPTH-entry register file with sync write and combinational read.

Test Plan:
- Basic run: top=9, len=3, entries {cmp2/hold1, cmp5/hold2, cmp8/hold1}, loop=0; start at t -> sel 2,3,1 at t+1..t+3 with d=9,0,2. Then sel=1 d=5 after 1 period, sel=1 d=8 after 2 more periods, done pulse after 1 more period; busy=0 afterwards.
- Loop: same table, loop=1 -> after entry 2, sel=1 d=2 appears again; no done pulse; stop -> busy=0 on next edge, sel=0.
- Hold 0: entry hold=0 -> behaves as hold=1 (one period before the next load).
- Ignored ops: cfg_we cmp=7 addr0 while busy -> table unchanged; start with len=0 -> busy stays 0; start & stop together in IDLE -> busy stays 0.
- Async reset in WAIT -> sel, d, busy, step_idx = 0 before the next clk edge.
- (PWM_SEQ_PINGPONG_EN) len=3, loop=1, pingpong=1 -> step_idx sequence 0,1,2,1,0,1,...

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM sequencer: FSM states, load-select
// encodings and the default table entry layout.
package pwm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_TOP = 3'd1,
    LOAD_CNT = 3'd2,
    LOAD_CMP = 3'd3,
    WAIT     = 3'd4
  } seq_state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_CMP  = 2'd1;
  localparam logic [1:0] SEL_TOP  = 2'd2;
  localparam logic [1:0] SEL_CNT  = 2'd3;

  localparam int SEQ_HOLD_W = 8;

  typedef struct packed {
    logic [15:0]           cmp;
    logic [SEQ_HOLD_W-1:0] hold;
  } seq_entry_t;

endpackage

// File: rtl/pwm_seq_table.sv
// Step table for the PWM sequencer: DEPTH registers with synchronous write,
// asynchronous clear and combinational read.
module pwm_seq_table #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pwm_sequencer.sv
// Drives the PWM counter load port from a programmed table of duty steps.
// Optional PWM_SEQ_PINGPONG_EN adds a 'pingpong' input for 0..N-1..0 looping.
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = SEQ_HOLD_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [15:0]       cfg_cmp,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [15:0]       cfg_top,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic              loop,
`ifdef PWM_SEQ_PINGPONG_EN
  input  logic              pingpong,
`endif
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       cnt_in,
  input  logic [15:0]       top_in,
  output logic [15:0]       d,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] step_idx
);

  typedef struct packed {
    logic [15:0]       cmp;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  seq_state_t        state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [15:0]       top_reg;
  logic [ADDR_W:0]   len_reg;
  logic              cfg_accept;
  logic              boundary;
  logic              not_last;
  entry_t            entry, wr_entry;
`ifdef PWM_SEQ_PINGPONG_EN
  logic              dir, dir_next;
`endif

  assign cfg_accept = cfg_we && (state == IDLE);
  assign boundary   = (cnt_in >= top_in);
  assign not_last   = ({1'b0, idx} < (len_reg - LEN_ONE));
  assign wr_entry   = '{cmp: cfg_cmp, hold: cfg_hold};

  pwm_seq_table #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (16 + HOLD_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_accept),
    .waddr (cfg_addr),
    .wdata (wr_entry),
    .raddr (idx),
    .rdata (entry)
  );

  // Sequence settings are only captured while idle; oversize lengths clamp to DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_reg <= '0;
      len_reg <= '0;
    end else if (cfg_accept) begin
      top_reg <= cfg_top;
      len_reg <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      hold_cnt <= hold_next;
    end
  end

`ifdef PWM_SEQ_PINGPONG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir <= 1'b0;
    else     dir <= dir_next;
  end
`endif

  always_comb begin
    state_next = state;
    idx_next   = idx;
    hold_next  = hold_cnt;
    sel        = SEL_NONE;
    d          = '0;
    done       = 1'b0;
`ifdef PWM_SEQ_PINGPONG_EN
    dir_next   = dir;
`endif
    case (state)
      IDLE: begin
        if (start && !stop && (len_reg != '0)) begin
          state_next = LOAD_TOP;
`ifdef PWM_SEQ_PINGPONG_EN
          dir_next   = 1'b0;
`endif
        end
      end
      LOAD_TOP: begin
        sel        = SEL_TOP;
        d          = top_reg;
        state_next = LOAD_CNT;
      end
      LOAD_CNT: begin
        sel        = SEL_CNT;
        d          = '0;
        idx_next   = '0;
        state_next = LOAD_CMP;
      end
      LOAD_CMP: begin
        sel        = SEL_CMP;
        d          = entry.cmp;
        hold_next  = (entry.hold == '0) ? HOLD_ONE : entry.hold;
        state_next = WAIT;
      end
      WAIT: begin
        // Count period boundaries; the last one of a step picks the next entry.
        if (boundary) begin
          if (hold_cnt != HOLD_ONE) begin
            hold_next = hold_cnt - HOLD_ONE;
          end else
`ifdef PWM_SEQ_PINGPONG_EN
          if (loop && pingpong && (len_reg > LEN_ONE)) begin
            state_next = LOAD_CMP;
            if (!dir) begin
              if (not_last) begin
                idx_next = idx + IDX_ONE;
              end else begin
                dir_next = 1'b1;
                idx_next = idx - IDX_ONE;
              end
            end else begin
              if (idx != '0) begin
                idx_next = idx - IDX_ONE;
              end else begin
                dir_next = 1'b0;
                idx_next = idx + IDX_ONE;
              end
            end
          end else
`endif
          if (not_last) begin
            idx_next   = idx + IDX_ONE;
            state_next = LOAD_CMP;
          end else if (loop) begin
            idx_next   = '0;
            state_next = LOAD_CMP;
          end else begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (stop && (state != IDLE)) begin
      state_next = IDLE;
      done       = 1'b0;
    end
  end

  assign busy     = (state != IDLE);
  assign step_idx = idx;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Table-driven self-checking bench for pwm_sequencer, plus hand-written
// sequences for asynchronous reset and (when enabled) ping-pong looping.
module tb_pwm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_cmp;
  logic [7:0]  cfg_hold;
  logic [15:0] cfg_top;
  logic [3:0]  cfg_len;
  logic        loop;
  logic        start;
  logic        stop;
  logic [15:0] cnt_in;
  logic [15:0] top_in;
  logic [15:0] d;
  logic [1:0]  sel;
  logic        busy;
  logic        done;
  logic [2:0]  step_idx;
`ifdef PWM_SEQ_PINGPONG_EN
  logic        pingpong;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] cmp;
    logic [7:0]  hold;
    logic [3:0]  len;
    logic        lp;
    logic        st;
    logic        sp;
    logic        bnd;
    logic [1:0]  eSel;
    logic [15:0] eD;
    logic        eBusy;
    logic        eDone;
    logic [2:0]  eIdx;
  } vec_t;

  vec_t vecs[$];

  pwm_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_cmp  (cfg_cmp),
    .cfg_hold (cfg_hold),
    .cfg_top  (cfg_top),
    .cfg_len  (cfg_len),
    .loop     (loop),
`ifdef PWM_SEQ_PINGPONG_EN
    .pingpong (pingpong),
`endif
    .start    (start),
    .stop     (stop),
    .cnt_in   (cnt_in),
    .top_in   (top_in),
    .d        (d),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic we, input logic [2:0] addr, input logic [15:0] cmp,
                        input logic [7:0] hold, input logic [3:0] len, input logic lp,
                        input logic st, input logic sp, input logic bnd,
                        input logic [1:0] eSel, input logic [15:0] eD, input logic eBusy,
                        input logic eDone, input logic [2:0] eIdx);
    vec_t v;
    v = '{we, addr, cmp, hold, len, lp, st, sp, bnd, eSel, eD, eBusy, eDone, eIdx};
    vecs.push_back(v);
  endtask

  // cnt_in sits at top (period boundary) or mid-period depending on bnd.
  task automatic applyStimulus(input vec_t v);
    cfg_we   = v.we;
    cfg_addr = v.addr;
    cfg_cmp  = v.cmp;
    cfg_hold = v.hold;
    cfg_top  = 16'd9;
    cfg_len  = v.len;
    loop     = v.lp;
    start    = v.st;
    stop     = v.sp;
    top_in   = 16'd9;
    cnt_in   = v.bnd ? 16'd9 : 16'd3;
  endtask

  task automatic checkOutput(input int n, input vec_t v);
    testsRun++;
    if (sel !== v.eSel || d !== v.eD || busy !== v.eBusy || done !== v.eDone || step_idx !== v.eIdx) begin
      testsFailed++;
      $display("[TB] FAIL vec%0d: got sel=%0d d=%0d busy=%0b done=%0b idx=%0d, want sel=%0d d=%0d busy=%0b done=%0b idx=%0d",
               n, sel, d, busy, done, step_idx, v.eSel, v.eD, v.eBusy, v.eDone, v.eIdx);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    cfg_we = 0; cfg_addr = 0; cfg_cmp = 0; cfg_hold = 0; cfg_top = 16'd9; cfg_len = 0;
    loop = 0; start = 0; stop = 0; cnt_in = 16'd3; top_in = 16'd9;
  endtask

`ifdef PWM_SEQ_PINGPONG_EN
  int ppExp[6] = '{0, 1, 2, 1, 0, 1};
`endif

  initial begin
    idleInputs();
`ifdef PWM_SEQ_PINGPONG_EN
    pingpong = 0;
`endif
    rst = 1;
    #12;
    checkValue("reset sel", int'(sel), 0);
    checkValue("reset d", int'(d), 0);
    checkValue("reset busy", int'(busy), 0);
    checkValue("reset idx", int'(step_idx), 0);
    rst = 0;

    // Configuration: top=9, len=3, entries {2/1, 5/2, 8/1}
    addVec(1,0,2,1,3,0,0,0,0, 0,0,0,0,0);
    addVec(1,1,5,2,3,0,0,0,0, 0,0,0,0,0);
    addVec(1,2,8,1,3,0,0,0,0, 0,0,0,0,0);
    // Basic non-looping run
    addVec(0,0,0,0,0,0,1,0,0, 0,0,0,0,0);
    addVec(0,0,0,0,0,0,0,0,0, 2,9,1,0,0);
    addVec(0,0,0,0,0,0,0,0,0, 3,0,1,0,0);
    addVec(0,0,0,0,0,0,0,0,0, 1,2,1,0,0);
    addVec(0,0,0,0,0,0,0,0,0, 0,0,1,0,0);
    addVec(0,0,0,0,0,0,0,0,1, 0,0,1,0,0);
    addVec(0,0,0,0,0,0,0,0,0, 1,5,1,0,1);
    addVec(0,0,0,0,0,0,0,0,1, 0,0,1,0,1);
    addVec(0,0,0,0,0,0,0,0,0, 0,0,1,0,1);
    addVec(0,0,0,0,0,0,0,0,1, 0,0,1,0,1);
    addVec(0,0,0,0,0,0,0,0,0, 1,8,1,0,2);
    addVec(0,0,0,0,0,0,0,0,1, 0,0,1,1,2);
    addVec(0,0,0,0,0,0,0,0,0, 0,0,0,0,2);
    // Looping run with a write attempt and a start while busy, then stop
    addVec(0,0,0,0,0,1,1,0,0, 0,0,0,0,2);
    addVec(1,0,7,1,3,1,0,0,0, 2,9,1,0,2);
    addVec(0,0,0,0,0,1,0,0,0, 3,0,1,0,2);
    addVec(0,0,0,0,0,1,0,0,0, 1,2,1,0,0);
    addVec(0,0,0,0,0,1,0,0,1, 0,0,1,0,0);
    addVec(0,0,0,0,0,1,0,0,0, 1,5,1,0,1);
    addVec(0,0,0,0,0,1,1,0,1, 0,0,1,0,1);
    addVec(0,0,0,0,0,1,0,0,1, 0,0,1,0,1);
    addVec(0,0,0,0,0,1,0,0,0, 1,8,1,0,2);
    addVec(0,0,0,0,0,1,0,0,1, 0,0,1,0,2);
    addVec(0,0,0,0,0,1,0,0,0, 1,2,1,0,0);
    addVec(0,0,0,0,0,1,0,1,0, 0,0,1,0,0);
    addVec(0,0,0,0,0,1,0,0,0, 0,0,0,0,0);
    // Hold of zero acts as one period
    addVec(1,1,5,0,2,0,0,0,0, 0,0,0,0,0);
    addVec(0,0,0,0,0,0,1,0,0, 0,0,0,0,0);
    addVec(0,0,0,0,0,0,0,0,0, 2,9,1,0,0);
    addVec(0,0,0,0,0,0,0,0,0, 3,0,1,0,0);
    addVec(0,0,0,0,0,0,0,0,0, 1,2,1,0,0);
    addVec(0,0,0,0,0,0,0,0,1, 0,0,1,0,0);
    addVec(0,0,0,0,0,0,0,0,0, 1,5,1,0,1);
    addVec(0,0,0,0,0,0,0,0,1, 0,0,1,1,1);
    addVec(0,0,0,0,0,0,0,0,0, 0,0,0,0,1);
    // Start with len=0 ignored; start with stop ignored
    addVec(1,3,1,1,0,0,0,0,0, 0,0,0,0,1);
    addVec(0,0,0,0,0,0,1,0,0, 0,0,0,0,1);
    addVec(0,0,0,0,0,0,0,0,0, 0,0,0,0,1);
    addVec(1,3,1,1,3,0,0,0,0, 0,0,0,0,1);
    addVec(0,0,0,0,0,0,1,1,0, 0,0,0,0,1);
    addVec(0,0,0,0,0,0,0,0,0, 0,0,0,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
    end

    // Asynchronous reset while waiting in step 1
    @(negedge clk); idleInputs(); cfg_len = 4'd3; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); cnt_in = 16'd9;
    @(negedge clk); cnt_in = 16'd3;
    @(negedge clk);
    #1;
    checkValue("pre-reset busy", int'(busy), 1);
    checkValue("pre-reset idx", int'(step_idx), 1);
    rst = 1;
    #1;
    checkValue("async reset sel", int'(sel), 0);
    checkValue("async reset d", int'(d), 0);
    checkValue("async reset busy", int'(busy), 0);
    checkValue("async reset idx", int'(step_idx), 0);
    @(negedge clk); rst = 0;

`ifdef PWM_SEQ_PINGPONG_EN
    for (int a = 0; a < 3; a++) begin
      @(negedge clk);
      cfg_we = 1; cfg_addr = 3'(a); cfg_cmp = 16'(a + 1); cfg_hold = 8'd1; cfg_len = 4'd3;
    end
    @(negedge clk); cfg_we = 0; loop = 1; pingpong = 1; start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkValue("pingpong idx0", int'(step_idx), ppExp[0]);
    cnt_in = 16'd9;
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      @(negedge clk);
      #1;
      checkValue($sformatf("pingpong idx%0d", k), int'(step_idx), ppExp[k]);
    end
    stop = 1;
    @(negedge clk); stop = 0; pingpong = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
